// File: rtl/pool_in_data_unpack.sv
// Stream-to-vector unpacker: gathers up to eight 32-bit beats into one 256-bit
// vector for the MAC/pooling array, lane k holding beat k of the vector.
module pool_in_data_unpack #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int VEC_WIDTH            = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [11:0]                     input_channel_size,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] in_data,
    input  logic                            in_last,
    output logic                            vec_valid,
    input  logic                            vec_ready,
    output logic [VEC_WIDTH-1:0]            vec_data,
    output logic                            vec_last,
    output logic                            layer_finish,
    output logic                            frame_err
);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    // ceil(ch/32) clamped to 1..8; anything at or above 256 channels needs all lanes
    function automatic logic [3:0] calc_beat_num(input logic [11:0] ch);
        logic [3:0] raw;
        raw = {1'b0, ch[7:5]} + {3'd0, |ch[4:0]};
        if (ch[11:8] != 4'd0) begin
            return 4'd8;
        end else if (raw == 4'd0) begin
            return 4'd1;
        end else begin
            return raw;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [3:0]             beat_cnt_q, beat_cnt_d;
    logic [3:0]             num_lat_q, num_lat_d;
    logic                   in_ready_q, in_ready_d;
    logic                   vec_valid_q, vec_valid_d;
    logic [VEC_WIDTH-1:0]   vec_data_q, vec_data_d;
    logic                   vec_last_q, vec_last_d;
    logic                   layer_finish_q, layer_finish_d;
    logic                   frame_err_q, frame_err_d;

    logic       beat_acc_s;
    logic [3:0] num_eff_s;
    logic       final_s;
    logic       close_s;
    logic       vec_hs_s;

    assign beat_acc_s = (state_q == FILL) && in_valid && in_ready_q;
    assign num_eff_s  = (beat_cnt_q == 4'd0) ? calc_beat_num(input_channel_size) : num_lat_q;
    assign final_s    = (beat_cnt_q == (num_eff_s - 4'd1));
    assign close_s    = beat_acc_s && (final_s || in_last);
    assign vec_hs_s   = (state_q == HOLD) && vec_valid_q && vec_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    state_d = close_s ? HOLD : FILL;
            HOLD:    state_d = vec_hs_s ? FILL : HOLD;
            default: state_d = FILL;
        endcase
    end

    // Next values for datapath and registered outputs
    always_comb begin
        beat_cnt_d     = beat_cnt_q;
        num_lat_d      = num_lat_q;
        in_ready_d     = in_ready_q;
        vec_valid_d    = vec_valid_q;
        vec_data_d     = vec_data_q;
        vec_last_d     = vec_last_q;
        layer_finish_d = 1'b0;
        frame_err_d    = frame_err_q;
        case (state_q)
            FILL: begin
                vec_valid_d = 1'b0;
                in_ready_d  = !close_s;
                if (beat_acc_s) begin
                    vec_data_d[{beat_cnt_q[2:0], 5'd0} +: 32] = in_data;
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    num_lat_d  = (beat_cnt_q == 4'd0) ? num_eff_s : num_lat_q;
                    vec_last_d = vec_last_q | in_last;
                    frame_err_d = frame_err_q | (in_last && !final_s);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            HOLD: begin
                if (vec_hs_s) begin
                    vec_valid_d    = 1'b0;
                    in_ready_d     = 1'b1;
                    beat_cnt_d     = 4'd0;
                    vec_data_d     = {VEC_WIDTH{1'b0}};
                    vec_last_d     = 1'b0;
                    layer_finish_d = vec_last_q;
                end else begin
                    vec_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                end
            end
            default: begin
                vec_valid_d = 1'b0;
                in_ready_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q     <= 4'd0;
            num_lat_q      <= 4'd1;
            in_ready_q     <= 1'b0;
            vec_valid_q    <= 1'b0;
            vec_data_q     <= {VEC_WIDTH{1'b0}};
            vec_last_q     <= 1'b0;
            layer_finish_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            beat_cnt_q     <= beat_cnt_d;
            num_lat_q      <= num_lat_d;
            in_ready_q     <= in_ready_d;
            vec_valid_q    <= vec_valid_d;
            vec_data_q     <= vec_data_d;
            vec_last_q     <= vec_last_d;
            layer_finish_q <= layer_finish_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign vec_valid    = vec_valid_q;
    assign vec_data     = vec_data_q;
    assign vec_last     = vec_last_q;
    assign layer_finish = layer_finish_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_pool_in_data_unpack.sv
// Bench for pool_in_data_unpack: directed scenarios plus random traffic, checked
// against a beat-list reference model of vector assembly.
module tb_pool_in_data_unpack;

    logic         clk;
    logic         rst_n;
    logic [11:0]  input_channel_size;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         vec_valid;
    logic         vec_ready;
    logic [255:0] vec_data;
    logic         vec_last;
    logic         layer_finish;
    logic         frame_err;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [255:0] exp_vec_q[$];
    logic         exp_last_q[$];
    logic [255:0] cur_vec;
    int           cur_cnt;
    int           cur_nb;
    logic         exp_fe;

    pool_in_data_unpack dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_channel_size (input_channel_size),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .in_last            (in_last),
        .vec_valid          (vec_valid),
        .vec_ready          (vec_ready),
        .vec_data           (vec_data),
        .vec_last           (vec_last),
        .layer_finish       (layer_finish),
        .frame_err          (frame_err)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int beats_for(input int ch);
        int n;
        n = (ch + 31) / 32;
        if (n < 1) n = 1;
        if (n > 8) n = 8;
        return n;
    endfunction

    task automatic model_clear();
        exp_vec_q.delete();
        exp_last_q.delete();
        cur_vec = '0;
        cur_cnt = 0;
        cur_nb  = 1;
        exp_fe  = 1'b0;
    endtask

    task automatic model_beat(input logic [31:0] d, input logic l, input int ch, output logic closed);
        closed = 1'b0;
        if (cur_cnt == 0) cur_nb = beats_for(ch);
        cur_vec[cur_cnt*32 +: 32] = d;
        cur_cnt++;
        if (cur_cnt == cur_nb || l) begin
            if (l && cur_cnt != cur_nb) exp_fe = 1'b1;
            exp_vec_q.push_back(cur_vec);
            exp_last_q.push_back(l);
            cur_vec = '0;
            cur_cnt = 0;
            closed  = 1'b1;
        end
    endtask

    // One clock cycle: drive inputs, predict handshakes, advance, check outputs
    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic vr);
        logic         acc, hs, pl, closed;
        logic [255:0] pv;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        vec_ready = vr;
        acc = v && in_ready;
        hs  = vec_valid && vr;
        pl  = 1'b0;
        pv  = '0;
        if (hs) begin
            if (exp_vec_q.size() == 0) begin
                check_val("vec_unexpected", 256'd1, 256'd0);
            end else begin
                pv = exp_vec_q.pop_front();
                pl = exp_last_q.pop_front();
                check_val("vec_data", vec_data, pv);
                check_val("vec_last", {255'd0, vec_last}, {255'd0, pl});
            end
        end
        @(posedge clk);
        #1;
        closed = 1'b0;
        if (acc) model_beat(d, l, int'(input_channel_size), closed);
        check_val("layer_finish", {255'd0, layer_finish}, {255'd0, hs && pl});
        check_val("in_ready", {255'd0, in_ready}, {255'd0, exp_vec_q.size() == 0});
        check_val("vec_valid", {255'd0, vec_valid}, {255'd0, (exp_vec_q.size() != 0) && !closed});
        check_val("frame_err", {255'd0, frame_err}, {255'd0, exp_fe});
        if (vec_valid && exp_vec_q.size() != 0) check_val("vec_hold", vec_data, exp_vec_q[0]);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        vec_ready = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_in_ready", {255'd0, in_ready}, 256'd0);
        check_val("rst_vec_valid", {255'd0, vec_valid}, 256'd0);
        check_val("rst_vec_data", vec_data, 256'd0);
        check_val("rst_vec_last", {255'd0, vec_last}, 256'd0);
        check_val("rst_layer_finish", {255'd0, layer_finish}, 256'd0);
        check_val("rst_frame_err", {255'd0, frame_err}, 256'd0);
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic send_beats(input int n, input logic [31:0] base, input int last_at);
        for (int i = 0; i < n; i++) begin
            // Repeat the beat until accepted; in_ready is bounded by vec_ready=1
            for (int t = 0; t < 20; t++) begin
                if (in_ready) begin
                    step(1'b1, base + 32'(i), (i == last_at), 1'b1);
                    break;
                end else begin
                    step(1'b0, 32'd0, 1'b0, 1'b1);
                end
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        input_channel_size = 12'd256;
        in_data = 32'd0;
        model_clear();
        do_reset();

        // Full 8-beat vector with data 1..8
        input_channel_size = 12'd256;
        send_beats(8, 32'd1, -1);
        drain(3);

        // 3-beat vectors, second closed by last on its final beat
        input_channel_size = 12'd70;
        send_beats(3, 32'hA, -1);
        send_beats(3, 32'hD, 2);
        drain(3);

        // Downstream stall: vector must stay put and no beats accepted
        input_channel_size = 12'd128;
        send_beats(4, 32'h100, -1);
        for (int i = 0; i < 10; i++) step(1'b1, 32'hDEAD, 1'b0, 1'b0);
        drain(3);

        // Early last mid-vector raises frame_err, which then stays set
        input_channel_size = 12'd256;
        send_beats(3, 32'h200, 2);
        drain(3);
        send_beats(8, 32'h300, -1);
        drain(3);

        // Channel-size extremes
        do_reset();
        input_channel_size = 12'd0;
        send_beats(3, 32'h400, 2);
        drain(2);
        input_channel_size = 12'd4095;
        send_beats(8, 32'h500, 7);
        drain(3);

        // Reset in the middle of a vector drops the partial lanes
        input_channel_size = 12'd256;
        send_beats(4, 32'h600, -1);
        do_reset();
        send_beats(8, 32'h700, -1);
        drain(3);

        // Random traffic, including mid-vector channel-size changes
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) input_channel_size = 12'($urandom_range(0, 4095));
            else if ($urandom_range(0, 15) == 0) input_channel_size = 12'($urandom_range(0, 300));
            step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) != 0));
        end
        drain(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
